spike_rate_decoder: RTL and testbench

//  Decodes the 1-bit spike train of a neuron core back into numbers, the reverse of the

---
 rtl/spike_rate_decoder.sv | 168 ++++++++++++++++
 tb/tb_spike_rate_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: turns a neuron core's 1-bit spike train back into numbers.
// A rate word is produced per fixed power-of-two window and handed out on a
// valid/ready handshake. Interspike intervals are measured alongside it.
//
// state | meaning
// IDLE  | not decoding; window, count and ISI timers held at 0
// COUNT | inside a window; counting spike edges and timing intervals
module spike_rate_decoder #(
   parameter int WINDOW_LOG2 = 8,
   parameter int CNT_W       = 8,
   parameter int ISI_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             spike,
   output logic [CNT_W-1:0] rate,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_overrun,
   output logic [ISI_W-1:0] isi,
   output logic             isi_valid
);

   // Window timer counts down the cycles left in the window; 0 marks the last cycle.
   localparam logic [WINDOW_LOG2-1:0] WIN_LAST      = '1;
   localparam logic [WINDOW_LOG2-1:0] WIN_FIRST_REM = WIN_LAST - 1'b1;
   localparam logic [CNT_W-1:0]       CNT_MAX       = '1;
   localparam logic [ISI_W-1:0]       ISI_MAX       = '1;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic                   spike_q;
   logic [WINDOW_LOG2-1:0] win_rem;
   logic [CNT_W-1:0]       count;
   logic [ISI_W-1:0]       isi_cnt;

   logic                   edge_det;
   logic                   start;
   logic                   run;
   logic                   win_end;
   logic [CNT_W-1:0]       count_final;

   // Edge detect and per-cycle qualifiers shared by the datapath blocks.
   // The start cycle is window cycle 0, so the remaining-cycle count loaded
   // there is already one short of WIN_LAST.
   always_comb begin
      edge_det    = spike & ~spike_q;
      start       = (state == IDLE) & enable & edge_det;
      run         = (state == COUNT) & enable;
      win_end     = run & (win_rem == '0);
      count_final = count;
      if (edge_det && (count != CNT_MAX)) begin
         count_final = count + 1'b1;
      end
   end

   // Next-state logic: an edge with enable set opens a window; dropping enable aborts it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = COUNT;
            end
         end
         COUNT: begin
            if (!enable) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Spike level history for edge detection, tracked regardless of enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spike_q <= 1'b0;
      end else begin
         spike_q <= spike;
      end
   end

   // Window timer and saturating edge counter; windows run back-to-back with no gap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_rem <= '0;
         count   <= '0;
      end else if (start) begin
         win_rem <= WIN_FIRST_REM;
         count   <= CNT_W'(1);
      end else if (run) begin
         if (win_rem == '0) begin
            win_rem <= WIN_LAST;
            count   <= '0;
         end else begin
            win_rem <= win_rem - 1'b1;
            count   <= count_final;
         end
      end else begin
         win_rem <= '0;
         count   <= '0;
      end
   end

   // Interval timer: holds cycles since the last edge. The opening edge of a
   // run only starts timing; every later edge publishes the interval.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         isi_cnt   <= '0;
         isi       <= '0;
         isi_valid <= 1'b0;
      end else begin
         isi_valid <= 1'b0;
         if (start) begin
            isi_cnt <= ISI_W'(1);
         end else if (run) begin
            if (edge_det) begin
               isi       <= isi_cnt;
               isi_valid <= 1'b1;
               isi_cnt   <= ISI_W'(1);
            end else if (isi_cnt != ISI_MAX) begin
               isi_cnt <= isi_cnt + 1'b1;
            end
         end else begin
            isi_cnt <= '0;
         end
      end
   end

   // Result register and handshake. A window result arriving while an
   // unaccepted one is held is dropped and flagged, so rate never changes
   // under a pending handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rate        <= '0;
         out_valid   <= 1'b0;
         out_overrun <= 1'b0;
      end else if (win_end) begin
         if (!out_valid || out_ready) begin
            rate        <= count_final;
            out_valid   <= 1'b1;
            out_overrun <= 1'b0;
         end else begin
            out_overrun <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid   <= 1'b0;
         out_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: directed scenarios plus random traffic,
// compared every cycle against a timestamp-based reference model.
module tb_spike_rate_decoder;

   localparam int WL      = 6;
   localparam int CW      = 5;
   localparam int IW      = 6;
   localparam int WIN     = 1 << WL;
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam int ISI_MAX = (1 << IW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          spike;
   logic [CW-1:0] rate;
   logic          out_valid;
   logic          out_ready;
   logic          out_overrun;
   logic [IW-1:0] isi;
   logic          isi_valid;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: absolute cycle stamps rather than counters.
   int cyc;
   bit m_spike_q;
   bit m_active;
   int m_win_start;
   int m_edges;
   int m_last_edge;
   int m_rate;
   bit m_valid;
   bit m_overrun;
   int m_isi;
   bit m_isi_valid;

   spike_rate_decoder #(
      .WINDOW_LOG2(WL),
      .CNT_W      (CW),
      .ISI_W      (IW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .spike      (spike),
      .rate       (rate),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_overrun(out_overrun),
      .isi        (isi),
      .isi_valid  (isi_valid)
   );

   always #5 clk = ~clk;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_spike_q   = 1'b0;
      m_active    = 1'b0;
      m_win_start = 0;
      m_edges     = 0;
      m_last_edge = 0;
      m_rate      = 0;
      m_valid     = 1'b0;
      m_overrun   = 1'b0;
      m_isi       = 0;
      m_isi_valid = 1'b0;
   endtask

   // One clock edge of the reference behaviour for the given inputs.
   task automatic model_step(input bit sp, input bit en, input bit rdy);
      bit rise;
      bit wend;
      int fin;
      rise        = sp && !m_spike_q;
      wend        = 1'b0;
      fin         = 0;
      m_isi_valid = 1'b0;
      if (!m_active) begin
         if (en && rise) begin
            m_active    = 1'b1;
            m_win_start = cyc;
            m_edges     = 1;
            m_last_edge = cyc;
         end
      end else if (!en) begin
         m_active = 1'b0;
      end else begin
         if (rise) begin
            m_edges++;
            m_isi       = imin(cyc - m_last_edge, ISI_MAX);
            m_isi_valid = 1'b1;
            m_last_edge = cyc;
         end
         if (cyc - m_win_start == WIN - 1) begin
            wend        = 1'b1;
            fin         = imin(m_edges, CNT_MAX);
            m_win_start = cyc + 1;
            m_edges     = 0;
         end
      end
      if (wend) begin
         if (!m_valid || rdy) begin
            m_rate    = fin;
            m_valid   = 1'b1;
            m_overrun = 1'b0;
         end else begin
            m_overrun = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid   = 1'b0;
         m_overrun = 1'b0;
      end
      m_spike_q = sp;
      cyc++;
   endtask

   task automatic check_outputs();
      check_val("rate", 32'(rate), 32'(m_rate));
      check_val("out_valid", 32'(out_valid), 32'(m_valid));
      check_val("out_overrun", 32'(out_overrun), 32'(m_overrun));
      check_val("isi", 32'(isi), 32'(m_isi));
      check_val("isi_valid", 32'(isi_valid), 32'(m_isi_valid));
   endtask

   // Called at a falling edge: drive inputs, advance the model, check at the next falling edge.
   task automatic step(input bit sp, input bit en, input bit rdy);
      spike     = sp;
      enable    = en;
      out_ready = rdy;
      model_step(sp, en, rdy);
      @(negedge clk);
      check_outputs();
   endtask

   // Asynchronous reset asserted between clock edges; outputs must clear before the next edge.
   task automatic reset_mid();
      model_step(spike, enable, out_ready);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_val("rst_rate", 32'(rate), 32'd0);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_overrun", 32'(out_overrun), 32'd0);
      check_val("rst_isi", 32'(isi), 32'd0);
      check_val("rst_isi_valid", 32'(isi_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      bit r_en;
      bit r_sp;
      int r_mode;
      cyc       = 0;
      reset     = 1'b1;
      enable    = 1'b0;
      spike     = 1'b0;
      out_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs();
      reset = 1'b0;

      // Periodic 1-cycle spikes every 16 cycles: 4 per window, isi 16.
      for (int i = 0; i < 4 * WIN + 10; i++) step(i % 16 == 0, 1'b1, 1'b1);
      check_val("s1_isi", 32'(isi), 32'd16);
      idle_cycles(5);

      // Spike held high 40 cycles counts once and yields no interval.
      for (int i = 0; i < WIN + 10; i++) step(i < 40, 1'b1, 1'b1);
      idle_cycles(5);

      // Consumer stalled over two window ends: 5 then 9 spikes.
      for (int i = 0; i < 2 * WIN; i++) begin
         step((i % 4 == 0) && ((i < 20) || (i >= WIN && i < WIN + 36)), 1'b1, 1'b0);
      end
      check_val("s3_rate_held", 32'(rate), 32'd5);
      check_val("s3_overrun", 32'(out_overrun), 32'd1);
      step(1'b0, 1'b1, 1'b1);
      check_val("s3_drain_valid", 32'(out_valid), 32'd0);
      check_val("s3_drain_overrun", 32'(out_overrun), 32'd0);
      idle_cycles(5);

      // Edge every 2 cycles saturates the rate; a long gap saturates isi.
      for (int i = 0; i < 2 * WIN; i++) step(i % 2 == 0, 1'b1, 1'b1);
      check_val("s4_rate_sat", 32'(rate), 32'(CNT_MAX));
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check_val("s4_isi_sat", 32'(isi), 32'(ISI_MAX));
      step(1'b0, 1'b1, 1'b1);
      idle_cycles(5);

      // Enable dropped mid-window after 7 spikes, then a fresh run.
      for (int i = 0; i < 40; i++) step((i % 5 == 0) && (i < 35), 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < WIN + 10; i++) step(i % 8 == 0, 1'b1, 1'b1);
      idle_cycles(5);

      // Reset mid-window while a result is pending and isi is nonzero.
      for (int i = 0; i < WIN + 20; i++) step(i % 6 == 0, 1'b1, 1'b0);
      reset_mid();
      for (int i = 0; i < WIN + 10; i++) step(i % 3 == 0, 1'b1, 1'b1);

      // Random traffic with occasional enable drops, stalls and resets.
      r_en = 1'b1;
      r_sp = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 400 == 0) r_mode = int'($urandom_range(0, 2));
         if ($urandom_range(0, 99) < 2) r_en = ~r_en;
         case (r_mode)
            0:       r_sp = ($urandom_range(0, 1) == 0);
            1:       r_sp = ($urandom_range(0, 9) == 0);
            default: r_sp = ($urandom_range(0, 99) == 0);
         endcase
         step(r_sp, r_en, $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 999) == 0) reset_mid();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
